inst_queue: RTL and testbench
=============================

// Module: inst_queue
// PURPOSE
//   Instruction buffer between inst_fetch and the decode stage.
//   - Captures {pc, inst} pairs returned by fetch and holds them in a small circular FIFO.
//   - Presents the pairs in order to decode over a valid/ready handshake.
//   - Decouples the fetch stream from decode stalls and mem_controller arbitration stalls.
//   - A flush drops all buffered instructions on a redirect (branch, trap).
// PARAMETERS
//   DEPTH   4   number of entries; power of two, >= 2
//   AW      2   pointer width = log2(DEPTH)
// PORTS
//   CLK          in   1    clock, rising edge
//   RESET        in   1    reset, asynchronous, active-low
//   flush        in   1    synchronous discard of all entries
//   in_valid     in   1    fetch presents an instruction this cycle
//   in_pc        in   64   address of in_inst
//   in_inst      in   32   fetched instruction word
//   in_ready     out  1    queue can accept a push this cycle
//   out_valid    out  1    head entry is valid
//   out_pc       out  64   head entry pc
//   out_inst     out  32   head entry instruction
//   out_misalign out  1    head entry pc[1:0] != 0
//   out_ready    in   1    decode consumes the head this cycle
//   count        out  AW+1 number of valid entries, 0..DEPTH
// BEHAVIOUR
//   - Storage: DEPTH x {pc[63:0], inst[31:0], misalign}.
//     - misalign = |in_pc[1:0] is captured at push time.
//     - Storage contents are not reset.
//   - Pointers: wr_ptr and rd_ptr are AW bits and wrap modulo DEPTH.
//     - count is an explicit register, not derived from the pointers.
//   - Reset (RESET=0, async): wr_ptr=rd_ptr=0, count=0.
//     - Outputs during reset: out_valid=0, in_ready=1, out_pc=0, out_inst=0, out_misalign=0.
//   - in_ready = (count != DEPTH). This is combinational from count only.
//     - It does not depend on out_ready, so there is no push-on-full even when a pop occurs in the same cycle.
//   - push = in_valid & in_ready & ~flush.
//   - out_valid = (count != 0).
//   - pop = out_valid & out_ready & ~flush.
//   - Head outputs: out_pc, out_inst and out_misalign are the entry at rd_ptr.
//     - They are forced to 0 when count == 0.
//   - Latency: a push is visible at the head the cycle after acceptance. There is no same-cycle bypass.
//   - Per rising edge:
//     - push only: write at wr_ptr; wr_ptr+1; count+1.
//     - pop only: rd_ptr+1; count-1.
//     - push & pop: write and advance both pointers; count unchanged. This is legal for 0 < count < DEPTH.
//     - flush: wr_ptr=rd_ptr=0, count=0. An in-flight push is dropped. Flush has priority over push and pop.
//   - Empty: out_ready is ignored. Count never underflows.
//   - Full: in_valid is ignored. Fetch must hold in_pc/in_inst until in_ready is seen high.
//   - Stability: while out_valid=1 and out_ready=0, the head outputs hold stable.
//   - RESET asserted mid-operation clears the queue immediately. Entries are lost.
// TESTING
//   1. Reset: RESET=0 with random inputs -> out_valid=0, in_ready=1, count=0. Release; idle -> unchanged.
//   2. Fill and drain.
//      - Fill: push pc=0x1000,0x1004,0x1008,0x100C with out_ready=0 -> count=4, in_ready=0.
//      - 5th push pc=0x1010 held -> not stored.
//      - Drain with out_ready=1 -> out_pc order 0x1000..0x100C, then out_valid=0.
//   3. Streaming.
//      - Continuous push, out_ready=1 from cycle 1 -> count steady at 1.
//      - One instruction out per cycle, order preserved over 2*DEPTH+1 pushes, exercising pointer wrap.
//   4. Flush.
//      - count=3; assert flush together with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0.
//      - The push is not stored; the first push after the flush appears alone at the head.
//   5. Misalign: push pc=0x2002, inst=0x00000013 -> head shows out_misalign=1, out_inst=0x00000013.
//   6. Backpressure: out_ready toggling pseudo-randomly against a scoreboard model.
//      - No loss, no duplicates.
//      - Head outputs stable while stalled.

Source files
------------

// File: rtl/inst_queue.sv
// inst_queue: in-order {pc, inst} FIFO between fetch and decode.
// Ports: CLK, RESET (async, active-low), flush, fetch push side
// (in_valid/in_pc/in_inst/in_ready), decode pop side (out_valid/out_pc/
// out_inst/out_misalign/out_ready) and the occupancy count.
module inst_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [63:0]   in_pc,
    input  logic [31:0]   in_inst,
    output logic          in_ready,
    output logic          out_valid,
    output logic [63:0]   out_pc,
    output logic [31:0]   out_inst,
    output logic          out_misalign,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [63:0]   pc_q  [DEPTH];
    logic [31:0]   ins_q [DEPTH];
    logic          mis_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    logic          push;
    logic          pop;

    // in_ready looks only at the count, so a full queue never takes a
    // push even when decode drains the head in the same cycle.
    assign in_ready  = (cnt_q != FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign count     = cnt_q;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Storage is unreset, so the head is masked while empty.
    assign out_pc       = out_valid ? pc_q[rd_ptr_q]  : '0;
    assign out_inst     = out_valid ? ins_q[rd_ptr_q] : '0;
    assign out_misalign = out_valid & mis_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_q[wr_ptr_q]  <= in_pc;
            ins_q[wr_ptr_q] <= in_inst;
            mis_q[wr_ptr_q] <= |in_pc[1:0];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: vector table, directed corner sequences and a randomized
// run against a queue-based reference model of the instruction buffer.
module tb_inst_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          flush;
    logic          in_valid;
    logic [63:0]   in_pc;
    logic [31:0]   in_inst;
    logic          in_ready;
    logic          out_valid;
    logic [63:0]   out_pc;
    logic [31:0]   out_inst;
    logic          out_misalign;
    logic          out_ready;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    inst_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_inst      (in_inst),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_pc       (out_pc),
        .out_inst     (out_inst),
        .out_misalign (out_misalign),
        .out_ready    (out_ready),
        .count        (count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [63:0] pc;
        logic        ordy;
        int          e_cnt;
        logic        e_val;
        logic        e_rdy;
        logic [63:0] e_pc;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } ent_t;

    vec_t vecs[$];
    ent_t mq[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [63:0] pc);
        return ~pc[31:0] ^ 32'h5A00_0000;
    endfunction

    task automatic idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
    endtask

    task automatic add(input logic fl, input logic iv, input logic [63:0] pc,
                       input logic ordy, input int ec, input logic ev,
                       input logic er, input logic [63:0] ep);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
        v.e_cnt = ec; v.e_val = ev; v.e_rdy = er; v.e_pc = ep;
        vecs.push_back(v);
    endtask

    initial begin
        logic        hold;
        logic        stall;
        logic [63:0] st_pc;
        logic [31:0] st_inst;
        logic        push_m;
        logic        pop_m;
        ent_t        e;

        // Reset with random inputs
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            flush     = 1'($urandom);
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_pc     = {$urandom, $urandom};
            in_inst   = $urandom;
            tick();
            chk("rst_valid", 64'(out_valid), 64'd0);
            chk("rst_ready", 64'(in_ready), 64'd1);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_pc", out_pc, 64'd0);
            chk("rst_inst", 64'(out_inst), 64'd0);
            chk("rst_mis", 64'(out_misalign), 64'd0);
        end
        idle();
        RESET = 1'b1;
        tick();
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd1);

        // Fill, held 5th push, drain, empty pop, then flush with push+pop
        add(0, 1, 64'h1000, 0, 1, 1, 1, 64'h1000);
        add(0, 1, 64'h1004, 0, 2, 1, 1, 64'h1000);
        add(0, 1, 64'h1008, 0, 3, 1, 1, 64'h1000);
        add(0, 1, 64'h100C, 0, 4, 1, 0, 64'h1000);
        add(0, 1, 64'h1010, 0, 4, 1, 0, 64'h1000);
        add(0, 1, 64'h1010, 0, 4, 1, 0, 64'h1000);
        add(0, 0, 64'h0,    1, 3, 1, 1, 64'h1004);
        add(0, 0, 64'h0,    1, 2, 1, 1, 64'h1008);
        add(0, 0, 64'h0,    1, 1, 1, 1, 64'h100C);
        add(0, 0, 64'h0,    1, 0, 0, 1, 64'h0);
        add(0, 0, 64'h0,    1, 0, 0, 1, 64'h0);
        add(0, 1, 64'h3000, 0, 1, 1, 1, 64'h3000);
        add(0, 1, 64'h3004, 0, 2, 1, 1, 64'h3000);
        add(0, 1, 64'h3008, 0, 3, 1, 1, 64'h3000);
        add(1, 1, 64'h300C, 1, 0, 0, 1, 64'h0);
        add(0, 1, 64'h3010, 0, 1, 1, 1, 64'h3010);
        add(0, 0, 64'h0,    1, 0, 0, 1, 64'h0);
        foreach (vecs[i]) begin
            flush     = vecs[i].fl;
            in_valid  = vecs[i].iv;
            in_pc     = vecs[i].pc;
            in_inst   = inst_of(vecs[i].pc);
            out_ready = vecs[i].ordy;
            tick();
            chk($sformatf("vec%0d_count", i), 64'(count),
                64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_valid", i), 64'(out_valid),
                64'(vecs[i].e_val));
            chk($sformatf("vec%0d_ready", i), 64'(in_ready),
                64'(vecs[i].e_rdy));
            chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
            chk($sformatf("vec%0d_inst", i), 64'(out_inst),
                vecs[i].e_val ? 64'(inst_of(vecs[i].e_pc)) : 64'd0);
        end
        idle();

        // Streaming: 2*DEPTH+1 pushes with decode always ready
        out_ready = 1'b1;
        for (int k = 0; k < 2*DEPTH+1; k++) begin
            in_valid = 1'b1;
            in_pc    = 64'h4000 + 64'(4*k);
            in_inst  = inst_of(in_pc);
            tick();
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc", out_pc, 64'h4000 + 64'(4*k));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_end", 64'(count), 64'd0);
        idle();

        // Misaligned pc
        in_valid = 1'b1;
        in_pc    = 64'h2002;
        in_inst  = 32'h0000_0013;
        tick();
        in_valid = 1'b0;
        chk("mis_flag", 64'(out_misalign), 64'd1);
        chk("mis_inst", 64'(out_inst), 64'h13);
        chk("mis_pc", out_pc, 64'h2002);
        out_ready = 1'b1;
        tick();
        chk("mis_drain", 64'(out_valid), 64'd0);
        idle();

        // Asynchronous reset mid-operation
        in_valid = 1'b1;
        in_pc    = 64'h5000;
        in_inst  = inst_of(in_pc);
        tick();
        in_pc    = 64'h5004;
        tick();
        idle();
        chk("pre_arst_count", 64'(count), 64'd2);
        #2 RESET = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        @(negedge CLK);
        RESET = 1'b1;
        tick();

        // Randomized backpressure against the reference queue
        hold  = 1'b0;
        stall = 1'b0;
        st_pc = '0;
        st_inst = '0;
        for (int c = 0; c < 600; c++) begin
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = {$urandom, $urandom};
                in_inst  = $urandom;
            end
            flush     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'($urandom);
            push_m = in_valid && (mq.size() != DEPTH) && !flush;
            pop_m  = (mq.size() != 0) && out_ready && !flush;
            stall  = (mq.size() != 0) && !out_ready && !flush;
            st_pc   = out_pc;
            st_inst = out_inst;
            hold = in_valid && !push_m && !flush;
            tick();
            if (flush) begin
                mq.delete();
            end else begin
                if (pop_m) void'(mq.pop_front());
                if (push_m) begin
                    e.pc = in_pc;
                    e.inst = in_inst;
                    mq.push_back(e);
                end
            end
            chk("rnd_count", 64'(count), 64'(mq.size()));
            chk("rnd_ready", 64'(in_ready), 64'(mq.size() != DEPTH));
            chk("rnd_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rnd_pc", out_pc, mq[0].pc);
                chk("rnd_inst", 64'(out_inst), 64'(mq[0].inst));
                chk("rnd_mis", 64'(out_misalign), 64'(|mq[0].pc[1:0]));
            end else begin
                chk("rnd_pc0", out_pc, 64'd0);
            end
            if (stall) begin
                chk("rnd_stable_pc", out_pc, st_pc);
                chk("rnd_stable_inst", 64'(out_inst), 64'(st_inst));
            end
        end

        // Drain what remains and confirm nothing extra appears
        idle();
        out_ready = 1'b1;
        while (mq.size() != 0) begin
            chk("drain_pc", out_pc, mq[0].pc);
            void'(mq.pop_front());
            tick();
        end
        chk("drain_empty", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
